// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the four-master AHB bridge arbiter.
package ahb_arb_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int IDX_W       = 2;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01,
    ST_LOCK = 2'b10
  } arb_state_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // A beat completes only for NONSEQ/SEQ transfers.
  function automatic logic is_beat(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// Request/grant bundle between the masters' side and the bridge arbiter.
interface ahb_bridge_arbiter_if;
  import ahb_arb_pkg::*;

  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic                   Hready;
  logic [1:0]             Htrans;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [IDX_W-1:0]       Hmaster;
  logic                   Hmastlock;

  modport master (
    output Hbusreq, Hlock, Hready, Htrans,
    input  Hgrant, Hmaster, Hmastlock
  );

  modport slave (
    input  Hbusreq, Hlock, Hready, Htrans,
    output Hgrant, Hmaster, Hmastlock
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after i_ptr, wrapping.
module rr_pick
  import ahb_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic                   o_vld,
  output logic [IDX_W-1:0]       o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Offset NUM_MASTERS wraps back to i_ptr itself, so the last owner ranks last.
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = i_ptr;
    w_cand = i_ptr;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_cand = i_ptr + IDX_W'(i);
      if (!o_vld && i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB bridge arbiter with locked-sequence support and a per-owner beat limit.
module ahb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int MAX_BEATS = 8
) (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  ahb_bridge_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAXB    = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] MAXB_M1 = CNT_W'(MAX_BEATS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  arb_state_t             r_state, w_nxt_state;
  logic [NUM_MASTERS-1:0] r_grant, w_nxt_grant;
  logic [IDX_W-1:0]       r_owner, w_nxt_owner;
  logic                   r_lock,  w_nxt_lock;
  logic [CNT_W-1:0]       r_cnt,   w_nxt_cnt;
  logic [IDX_W-1:0]       r_ptr,   w_nxt_ptr;

  logic             w_pick_vld;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_own_req;
  logic             w_own_lock;
  logic             w_beat;
  logic             w_cnt_hit;
  logic             w_arb;

  rr_pick u_pick (
    .i_req (bus.Hbusreq),
    .i_ptr (r_ptr),
    .o_vld (w_pick_vld),
    .o_idx (w_pick_idx)
  );

  assign w_own_req  = bus.Hbusreq[r_owner];
  assign w_own_lock = bus.Hlock[r_owner];
  assign w_beat     = bus.Hready && is_beat(bus.Htrans);
  // Limit fires one beat early so the owner gets exactly MAX_BEATS completed transfers.
  assign w_cnt_hit  = (r_cnt == MAXB) || ((r_cnt == MAXB_M1) && w_beat);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_owner = r_owner;
    w_nxt_lock  = r_lock;
    w_nxt_cnt   = r_cnt;
    w_nxt_ptr   = r_ptr;
    w_arb       = 1'b0;

    if (bus.Hready) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) w_arb = 1'b1;
        end
        ST_OWN: begin
          if (w_own_req && w_own_lock) begin
            w_nxt_state = ST_LOCK;
            w_nxt_lock  = 1'b1;
          end else if (!w_own_req || w_cnt_hit) begin
            w_arb = 1'b1;
          end else if (w_beat && (r_cnt != MAXB)) begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_LOCK: begin
          if (!w_own_lock) w_arb = 1'b1;
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_grant = '0;
          w_nxt_lock  = 1'b0;
          w_nxt_cnt   = '0;
        end
      endcase

      // Every arbitration restarts the beat budget, including a regrant to the same owner.
      if (w_arb) begin
        w_nxt_cnt  = '0;
        w_nxt_lock = 1'b0;
        if (w_pick_vld) begin
          w_nxt_state = ST_OWN;
          w_nxt_grant = ONE_HOT0 << w_pick_idx;
          w_nxt_owner = w_pick_idx;
          w_nxt_ptr   = w_pick_idx;
        end else begin
          w_nxt_state = ST_IDLE;
          w_nxt_grant = '0;
        end
      end
    end
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_lock  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_nxt_state;
      r_grant <= w_nxt_grant;
      r_owner <= w_nxt_owner;
      r_lock  <= w_nxt_lock;
      r_cnt   <= w_nxt_cnt;
      r_ptr   <= w_nxt_ptr;
    end
  end

  assign bus.Hgrant    = r_grant;
  assign bus.Hmaster   = r_owner;
  assign bus.Hmastlock = r_lock;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter: reset, rotation, lock, stall and regrant scenarios.
module tb_ahb_bridge_arbiter;

  logic Hclk = 1'b0;
  logic Hresetn;
  int   errors = 0;
  int   checks = 0;

  ahb_bridge_arbiter_if bus ();

  ahb_bridge_arbiter #(.MAX_BEATS(8)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  always #5 Hclk = ~Hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic do_reset();
    Hresetn     = 1'b0;
    bus.Hbusreq = 4'b0000;
    bus.Hlock   = 4'b0000;
    bus.Hready  = 1'b1;
    bus.Htrans  = 2'b00;
    tick();
    Hresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    Hresetn = 1'b0;
    tick();
    tick();
    checks++; if (bus.Hgrant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", bus.Hgrant); end
    checks++; if (bus.Hmaster !== 2'd0) begin errors++; $display("FAIL reset_master: got %0d want 0", bus.Hmaster); end
    checks++; if (bus.Hmastlock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", bus.Hmastlock); end
    Hresetn = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.Hbusreq = 4'b0001;
    tick();
    checks++; if (bus.Hgrant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", bus.Hgrant); end
    checks++; if (bus.Hmaster !== 2'd0) begin errors++; $display("FAIL single_master: got %0d want 0", bus.Hmaster); end
    bus.Hbusreq = 4'b0000;
    tick();
    checks++; if (bus.Hgrant !== 4'b0000) begin errors++; $display("FAIL release_idle: got %b want 0000", bus.Hgrant); end
    checks++; if (bus.Hmaster !== 2'd0) begin errors++; $display("FAIL idle_hold_master: got %0d want 0", bus.Hmaster); end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_g;
    logic [1:0] exp_m;
    do_reset();
    bus.Hbusreq = 4'b1111;
    bus.Htrans  = 2'b10;
    for (int k = 1; k <= 33; k++) begin
      tick();
      exp_m = 2'(((k - 1) / 8) % 4);
      exp_g = 4'b0001 << exp_m;
      checks++; if (bus.Hgrant !== exp_g) begin errors++; $display("FAIL rotate_grant cyc%0d: got %b want %b", k, bus.Hgrant, exp_g); end
      checks++; if (bus.Hmaster !== exp_m) begin errors++; $display("FAIL rotate_master cyc%0d: got %0d want %0d", k, bus.Hmaster, exp_m); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus.Hbusreq = 4'b0100;
    bus.Htrans  = 2'b10;
    tick();
    checks++; if (bus.Hgrant !== 4'b0100) begin errors++; $display("FAIL lock_owner: got %b want 0100", bus.Hgrant); end
    bus.Hbusreq = 4'b1111;
    bus.Hlock   = 4'b0100;
    tick();
    checks++; if (bus.Hmastlock !== 1'b1) begin errors++; $display("FAIL lock_enter: got %b want 1", bus.Hmastlock); end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (bus.Hgrant !== 4'b0100 || bus.Hmastlock !== 1'b1) begin
        errors++; $display("FAIL lock_hold beat%0d: got grant=%b lock=%b want 0100/1", k, bus.Hgrant, bus.Hmastlock);
      end
    end
    bus.Hlock = 4'b0000;
    tick();
    checks++; if (bus.Hgrant !== 4'b1000) begin errors++; $display("FAIL lock_exit_grant: got %b want 1000", bus.Hgrant); end
    checks++; if (bus.Hmaster !== 2'd3) begin errors++; $display("FAIL lock_exit_master: got %0d want 3", bus.Hmaster); end
    checks++; if (bus.Hmastlock !== 1'b0) begin errors++; $display("FAIL lock_exit_lock: got %b want 0", bus.Hmastlock); end
  endtask

  task automatic test_hready_freeze();
    do_reset();
    bus.Hbusreq = 4'b0010;
    bus.Htrans  = 2'b10;
    tick();
    checks++; if (bus.Hgrant !== 4'b0010) begin errors++; $display("FAIL freeze_owner: got %b want 0010", bus.Hgrant); end
    bus.Hbusreq = 4'b0110;
    tick();
    bus.Hready  = 1'b0;
    bus.Hbusreq = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.Hgrant !== 4'b0010) begin errors++; $display("FAIL freeze_hold cyc%0d: got %b want 0010", k, bus.Hgrant); end
    end
    bus.Hready = 1'b1;
    tick();
    checks++; if (bus.Hgrant !== 4'b0100) begin errors++; $display("FAIL freeze_release: got %b want 0100", bus.Hgrant); end
    checks++; if (bus.Hmaster !== 2'd2) begin errors++; $display("FAIL freeze_master: got %0d want 2", bus.Hmaster); end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    bus.Hbusreq = 4'b1000;
    bus.Htrans  = 2'b11;
    tick();
    bus.Hlock = 4'b1000;
    tick();
    checks++; if (bus.Hmastlock !== 1'b1) begin errors++; $display("FAIL midlock_enter: got %b want 1", bus.Hmastlock); end
    Hresetn     = 1'b0;
    bus.Hbusreq = 4'b0110;
    bus.Hlock   = 4'b0000;
    tick();
    checks++; if (bus.Hgrant !== 4'b0000) begin errors++; $display("FAIL midlock_rst_grant: got %b want 0000", bus.Hgrant); end
    checks++; if (bus.Hmastlock !== 1'b0) begin errors++; $display("FAIL midlock_rst_lock: got %b want 0", bus.Hmastlock); end
    Hresetn = 1'b1;
    tick();
    checks++; if (bus.Hgrant !== 4'b0010) begin errors++; $display("FAIL midlock_first_grant: got %b want 0010", bus.Hgrant); end
    checks++; if (bus.Hmaster !== 2'd1) begin errors++; $display("FAIL midlock_first_master: got %0d want 1", bus.Hmaster); end
  endtask

  task automatic test_regrant();
    do_reset();
    bus.Hbusreq = 4'b0001;
    bus.Htrans  = 2'b10;
    tick();
    // Edges 2..9: the ninth edge regrants master 0 with a fresh budget.
    for (int k = 2; k <= 9; k++) begin
      tick();
      checks++; if (bus.Hgrant !== 4'b0001) begin errors++; $display("FAIL regrant_hold cyc%0d: got %b want 0001", k, bus.Hgrant); end
    end
    bus.Hbusreq = 4'b0011;
    for (int k = 10; k <= 16; k++) begin
      tick();
      checks++; if (bus.Hgrant !== 4'b0001) begin errors++; $display("FAIL regrant_budget cyc%0d: got %b want 0001", k, bus.Hgrant); end
    end
    tick();
    checks++; if (bus.Hgrant !== 4'b0010) begin errors++; $display("FAIL regrant_handoff: got %b want 0010", bus.Hgrant); end
  endtask

  initial begin
    Hresetn     = 1'b0;
    bus.Hbusreq = 4'b0000;
    bus.Hlock   = 4'b0000;
    bus.Hready  = 1'b1;
    bus.Htrans  = 2'b00;
    test_reset();
    test_single();
    test_rotate();
    test_lock();
    test_hready_freeze();
    test_reset_mid_lock();
    test_regrant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
